// File: rtl/midi_msg_merger.sv
// midi_msg_merger: merges NUM_IN received MIDI byte streams onto one transmit
// byte stream without splitting messages, and resolves running status per input.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   rx_data/rx_valid     per-input received bytes (input i at [8i+7:8i]), no backpressure
//   tx_data/tx_valid     merged byte, held until tx_ready
//   tx_ready             transmitter accepts when tx_valid && tx_ready
//   sel_set/sel_clr      pulses that set/clear out_en bits (clear wins)
//   out_en               registered per-output enable
//   ovf/ovf_clr          sticky per-input FIFO overflow flag and its clear pulse
module midi_msg_merger #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned NUM_OUT    = 4,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*NUM_IN-1:0]   rx_data,
    input  logic [NUM_IN-1:0]     rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [NUM_OUT-1:0]    sel_set,
    input  logic [NUM_OUT-1:0]    sel_clr,
    output logic [NUM_OUT-1:0]    out_en,
    output logic [NUM_IN-1:0]     ovf,
    input  logic [NUM_IN-1:0]     ovf_clr
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned IW = $clog2(NUM_IN);
    localparam int unsigned SW = IW + 1;

    typedef enum logic [1:0] {IDLE, INS_STATUS, SEND, SYSEX} state_t;

    logic [7:0]                  mem [NUM_IN][FIFO_DEPTH];
    logic [NUM_IN-1:0][PW-1:0]   wr_ptr, rd_ptr;
    logic [NUM_IN-1:0][7:0]      head_byte;
    logic [NUM_IN-1:0]           empty, full, wr_en, pop;
    logic [NUM_IN-1:0][7:0]      rs_byte;
    logic [NUM_IN-1:0]           rs_vld;

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d, rr_q, rr_d, cand;
    logic [1:0]      rem_q, rem_d;
    logic [SW-1:0]   srch;
    logic            found, slot_free, emit, rs_ld, rs_clr, g_empty;
    logic [7:0]      emit_byte, c_head, g_head;

    // Total message length implied by a status byte (data bytes never reach here).
    function automatic logic [1:0] msg_len(input logic [7:0] b);
        logic [1:0] n;
        n = 2'd1;
        if (b < 8'hC0)                    n = 2'd3;
        else if (b < 8'hE0)               n = 2'd2;
        else if (b < 8'hF0)               n = 2'd3;
        else if (b == 8'hF1 || b == 8'hF3) n = 2'd2;
        else if (b == 8'hF2)              n = 2'd3;
        return n;
    endfunction

    function automatic logic [IW-1:0] rr_after(input logic [IW-1:0] g);
        return (32'(g) == NUM_IN - 1) ? '0 : g + IW'(1);
    endfunction

    // FIFO status and head bytes
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            head_byte[i] = mem[i][rd_ptr[i][AW-1:0]];
            empty[i]     = (wr_ptr[i] == rd_ptr[i]);
            full[i]      = (wr_ptr[i][PW-1] != rd_ptr[i][PW-1]) &&
                           (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
        end
    end

    // A pop in the same cycle frees the slot for a write into a full FIFO
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            wr_en[i] = rx_valid[i] && (!full[i] || pop[i]);
        end
    end

    // Round-robin search for the first non-empty FIFO starting at rr_q
    always_comb begin
        found = 1'b0;
        cand  = rr_q;
        srch  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            srch = {1'b0, rr_q} + SW'(k);
            if (srch >= SW'(NUM_IN)) srch = srch - SW'(NUM_IN);
            if (!found && !empty[srch[IW-1:0]]) begin
                found = 1'b1;
                cand  = srch[IW-1:0];
            end
        end
    end

    assign c_head    = head_byte[cand];
    assign g_head    = head_byte[grant_q];
    assign g_empty   = empty[grant_q];
    assign slot_free = !tx_valid || tx_ready;

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            rem_q   <= rem_d;
        end
    end

    // Arbiter next state; IDLE emits a status head directly to meet two-cycle latency
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        rem_d     = rem_q;
        pop       = '0;
        emit      = 1'b0;
        emit_byte = '0;
        rs_ld     = 1'b0;
        rs_clr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = cand;
                    if (!c_head[7]) begin
                        if (rs_vld[cand]) state_d = INS_STATUS;
                        else              pop[cand] = 1'b1;
                    end else if (slot_free) begin
                        pop[cand] = 1'b1;
                        emit      = 1'b1;
                        emit_byte = c_head;
                        if (c_head == 8'hF0) begin
                            rs_clr  = 1'b1;
                            state_d = SYSEX;
                        end else begin
                            if (c_head < 8'hF0)      rs_ld  = 1'b1;
                            else if (c_head < 8'hF8) rs_clr = 1'b1;
                            if (msg_len(c_head) == 2'd1) begin
                                rr_d = rr_after(cand);
                            end else begin
                                rem_d   = msg_len(c_head) - 2'd1;
                                state_d = SEND;
                            end
                        end
                    end
                end
            end
            INS_STATUS: begin
                if (slot_free) begin
                    emit      = 1'b1;
                    emit_byte = rs_byte[grant_q];
                    rem_d     = msg_len(rs_byte[grant_q]) - 2'd1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (!g_empty) begin
                    if (g_head >= 8'hF8) begin
                        if (slot_free) begin
                            pop[grant_q] = 1'b1;
                            emit         = 1'b1;
                            emit_byte    = g_head;
                        end
                    end else if (g_head[7]) begin
                        state_d = IDLE;
                    end else if (slot_free) begin
                        pop[grant_q] = 1'b1;
                        emit         = 1'b1;
                        emit_byte    = g_head;
                        rem_d        = rem_q - 2'd1;
                        if (rem_q == 2'd1) begin
                            state_d = IDLE;
                            rr_d    = rr_after(grant_q);
                        end
                    end
                end
            end
            SYSEX: begin
                if (!g_empty) begin
                    if (g_head == 8'hF7) begin
                        if (slot_free) begin
                            pop[grant_q] = 1'b1;
                            emit         = 1'b1;
                            emit_byte    = g_head;
                            state_d      = IDLE;
                            rr_d         = rr_after(grant_q);
                        end
                    end else if (g_head[7] && g_head < 8'hF8) begin
                        state_d = IDLE;
                    end else if (slot_free) begin
                        pop[grant_q] = 1'b1;
                        emit         = 1'b1;
                        emit_byte    = g_head;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage (contents need no reset; pointers define validity)
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (wr_en[i]) mem[i][wr_ptr[i][AW-1:0]] <= rx_data[8*i +: 8];
        end
    end

    // FIFO pointers and sticky overflow; a new overflow beats ovf_clr
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (pop[i])   rd_ptr[i] <= rd_ptr[i] + PW'(1);
                if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (rx_valid[i] && !wr_en[i]) ovf[i] <= 1'b1;
                else if (ovf_clr[i])          ovf[i] <= 1'b0;
            end
        end
    end

    // Per-input running status
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_vld  <= '0;
            rs_byte <= '0;
        end else if (rs_ld) begin
            rs_vld[cand]  <= 1'b1;
            rs_byte[cand] <= c_head;
        end else if (rs_clr) begin
            rs_vld[cand]  <= 1'b0;
        end
    end

    // Output byte register
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (emit) begin
            tx_valid <= 1'b1;
            tx_data  <= emit_byte;
        end else if (tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

    // Output enables; clear wins over set
    always_ff @(posedge clk) begin
        if (rst) out_en <= '0;
        else     out_en <= (out_en | sel_set) & ~sel_clr;
    end
endmodule

// File: tb/tb_midi_msg_merger.sv
// Self-checking bench for midi_msg_merger: scoreboard of expected merged bytes
// popped and compared on each accepted transfer, plus direct register checks.
module tb_midi_msg_merger;
    localparam int unsigned NI = 4;
    localparam int unsigned NO = 4;
    localparam int unsigned FD = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [8*NI-1:0] rx_data = '0;
    logic [NI-1:0]   rx_valid = '0;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready = 1'b1;
    logic [NO-1:0]   sel_set = '0;
    logic [NO-1:0]   sel_clr = '0;
    logic [NO-1:0]   out_en;
    logic [NI-1:0]   ovf;
    logic [NI-1:0]   ovf_clr = '0;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic       rdy_rand = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] held = '0;

    midi_msg_merger #(.NUM_IN(NI), .NUM_OUT(NO), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .sel_set(sel_set), .sel_clr(sel_clr), .out_en(out_en),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp1(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic strobe(input logic [NI-1:0] v, input logic [8*NI-1:0] d);
        rx_valid = v;
        rx_data  = d;
        tick();
        rx_valid = '0;
        rx_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (4) tick();
    endtask

    // Random backpressure when enabled
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_rand) tx_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: scoreboard compare on accept, stability while stalled
    initial forever begin
        @(negedge clk);
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(held));
            end
            stall = tx_valid && !tx_ready;
            held  = tx_data;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) check("spurious_byte", 32'(tx_data), 32'h100);
                else                   check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        do_reset();
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_out_en", 32'(out_en), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // Latency: byte into empty FIFO visible two cycles after its strobe
        exp1(8'hF8);
        strobe(4'b0001, 32'h0000_00F8);
        check("lat_cyc1_valid", 32'(tx_valid), 32'd0);
        tick();
        check("lat_cyc2_valid", 32'(tx_valid), 32'd1);
        check("lat_cyc2_data", 32'(tx_data), 32'hF8);
        drain(50);

        // Collision under random backpressure
        do_reset();
        rdy_rand = 1'b1;
        exp1(8'h90); exp1(8'h3C); exp1(8'h64); exp1(8'h80); exp1(8'h3C); exp1(8'h00);
        strobe(4'b0011, 32'h0000_8090);
        strobe(4'b0011, 32'h0000_3C3C);
        strobe(4'b0011, 32'h0000_0064);
        drain(200);
        rdy_rand = 1'b0;
        tx_ready = 1'b1;
        check("coll_ovf", 32'(ovf), 32'd0);

        // Running status reinsertion after another input's message
        do_reset();
        exp1(8'h90); exp1(8'h40); exp1(8'h7F);
        strobe(4'b0100, 32'h0090_0000);
        strobe(4'b0100, 32'h0040_0000);
        strobe(4'b0100, 32'h007F_0000);
        drain(50);
        exp1(8'h92); exp1(8'h10); exp1(8'h20); exp1(8'h90); exp1(8'h41); exp1(8'h7F);
        strobe(4'b1100, 32'h9241_0000);
        strobe(4'b1100, 32'h107F_0000);
        strobe(4'b1000, 32'h2000_0000);
        drain(50);

        // Realtime inline does not count toward message length
        do_reset();
        exp1(8'h90); exp1(8'hF8); exp1(8'h3C); exp1(8'h64); exp1(8'hC0); exp1(8'h05);
        strobe(4'b0001, 32'h0000_0090);
        strobe(4'b0001, 32'h0000_00F8);
        strobe(4'b0001, 32'h0000_003C);
        strobe(4'b0001, 32'h0000_0064);
        strobe(4'b0010, 32'h0000_C000);
        strobe(4'b0010, 32'h0000_0500);
        drain(50);

        // SysEx holds the grant; input0 only after F7
        do_reset();
        exp1(8'hF0); exp1(8'h7E); exp1(8'h01); exp1(8'hF7);
        exp1(8'h90); exp1(8'h3C); exp1(8'h64); exp1(8'h80); exp1(8'h3C); exp1(8'h00);
        strobe(4'b0010, 32'h0000_F000);
        strobe(4'b0011, 32'h0000_7E90);
        strobe(4'b0011, 32'h0000_013C);
        strobe(4'b0011, 32'h0000_F764);
        strobe(4'b0001, 32'h0000_0080);
        strobe(4'b0001, 32'h0000_003C);
        strobe(4'b0001, 32'h0000_0000);
        drain(50);

        // Overflow: output register occupied, FD+2 bytes into input3
        do_reset();
        tx_ready = 1'b0;
        exp1(8'hF8);
        strobe(4'b0001, 32'h0000_00F8);
        tick();
        for (int i = 0; i < FD + 2; i++) begin
            if (i < FD) exp1(8'hF8 + 8'(i % 8));
            strobe(4'b1000, {8'hF8 + 8'(i % 8), 24'h0});
        end
        check("ovf_set", 32'(ovf), 32'h8);
        ovf_clr = 4'b1000;
        tick();
        ovf_clr = '0;
        check("ovf_clr", 32'(ovf), 32'h0);
        ovf_clr = 4'b1000;
        strobe(4'b1000, 32'hFE00_0000);
        ovf_clr = '0;
        check("ovf_beats_clr", 32'(ovf), 32'h8);
        ovf_clr = 4'b1000;
        tick();
        ovf_clr = '0;
        check("ovf_clr2", 32'(ovf), 32'h0);
        tx_ready = 1'b1;
        drain(200);
        check("ovf_after_drain", 32'(ovf), 32'h0);

        // Output enables and reset mid-message
        do_reset();
        sel_set = 4'b0101;
        tick();
        sel_set = '0;
        check("en_set", 32'(out_en), 32'h5);
        sel_set = 4'b0001;
        sel_clr = 4'b0001;
        tick();
        sel_set = '0;
        sel_clr = '0;
        check("en_clr_wins", 32'(out_en), 32'h4);
        tx_ready = 1'b0;
        strobe(4'b0001, 32'h0000_0090);
        strobe(4'b0001, 32'h0000_003C);
        tick();
        check("pre_rst_valid", 32'(tx_valid), 32'd1);
        check("pre_rst_data", 32'(tx_data), 32'h90);
        rst = 1'b1;
        tick();
        check("midrst_valid", 32'(tx_valid), 32'd0);
        check("midrst_out_en", 32'(out_en), 32'd0);
        check("midrst_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        tx_ready = 1'b1;
        // Data byte with running status cleared by reset is discarded
        strobe(4'b0001, 32'h0000_0064);
        repeat (10) tick();
        check("post_rst_idle", 32'(tx_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
